dac_share_ctrl: RTL and testbench

Scheduler that shares the single serial DAC path (da2dac command/data/strobe interface) between two sample requesters. Port A carries the modulator stream (BPSK+AWGN samples). Port B carries calibration/test writes. The block arbitrates between the ports round-robin, issues one DAC transaction at a time, waits for the serializer's completion flag, enforces a guard gap between transactions, and flags serializer hangs. It sits between the datapath sources and da2dac, in place of a fixed single-source controller.

---
 rtl/dac_share_ctrl.sv | 105 ++++++++++
 tb/tb_dac_share_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/dac_share_ctrl.sv
// dac_share_ctrl: round-robin scheduler sharing one serial DAC path between two requesters
module dac_share_ctrl #(
  parameter int DW      = 12,
  parameter int HOLDOFF = 2,
  parameter int TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          n_reset,
  input  logic          enable,
  input  logic          req_a,
  input  logic [DW-1:0] data_a,
  input  logic [1:0]    cmd_a,
  output logic          ack_a,
  input  logic          req_b,
  input  logic [DW-1:0] data_b,
  input  logic [1:0]    cmd_b,
  output logic          ack_b,
  output logic          dacdav,
  output logic [1:0]    daccmd,
  output logic [DW-1:0] dacdata,
  input  logic          davdac,
  output logic          busy,
  output logic          last_grant,
  output logic          timeout_err
);
  typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;
  localparam logic [7:0] TLAST = 8'(TIMEOUT - 1);
  localparam logic [3:0] HLOAD = 4'(HOLDOFF - 1);
  state_t state, state_n;
  logic [7:0] tcnt, tcnt_n, tinc;
  logic [3:0] hcnt, hcnt_n;
  logic ack_a_n, ack_b_n, dav_n, lg_n, err_n, grant, pick_b, done;
  logic [1:0] cmd_n;
  logic [DW-1:0] data_n;
  assign busy = state != IDLE;
  assign grant = enable && (req_a || req_b);
  assign pick_b = req_b && (!req_a || !last_grant);
  // a done flag still high from the previous transaction must not complete this one
  assign done = davdac && !dacdav;
  assign tinc = tcnt + 8'd1;
  always_comb begin
    state_n = state;
    tcnt_n  = tcnt;
    hcnt_n  = hcnt;
    ack_a_n = 1'b0;
    ack_b_n = 1'b0;
    dav_n   = 1'b0;
    lg_n    = last_grant;
    err_n   = timeout_err;
    cmd_n   = daccmd;
    data_n  = dacdata;
    case (state)
      IDLE: if (grant) begin
        state_n = WAIT;
        tcnt_n  = 8'd0;
        ack_a_n = !pick_b;
        ack_b_n = pick_b;
        dav_n   = 1'b1;
        lg_n    = pick_b;
        cmd_n   = pick_b ? cmd_b : cmd_a;
        data_n  = pick_b ? data_b : data_a;
      end
      WAIT: if (done) begin
        state_n = HOLD;
        hcnt_n  = HLOAD;
      end else if (tinc == TLAST) begin
        state_n = HOLD;
        hcnt_n  = HLOAD;
        err_n   = 1'b1;
      end else begin
        tcnt_n = tinc;
      end
      HOLD: begin
        state_n = hcnt == 4'd0 ? IDLE : HOLD;
        hcnt_n  = hcnt == 4'd0 ? 4'd0 : hcnt - 4'd1;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state       <= IDLE;
      tcnt        <= 8'd0;
      hcnt        <= 4'd0;
      ack_a       <= 1'b0;
      ack_b       <= 1'b0;
      dacdav      <= 1'b0;
      last_grant  <= 1'b1;
      timeout_err <= 1'b0;
      daccmd      <= 2'd0;
      dacdata     <= '0;
    end else begin
      state       <= state_n;
      tcnt        <= tcnt_n;
      hcnt        <= hcnt_n;
      ack_a       <= ack_a_n;
      ack_b       <= ack_b_n;
      dacdav      <= dav_n;
      last_grant  <= lg_n;
      timeout_err <= err_n;
      daccmd      <= cmd_n;
      dacdata     <= data_n;
    end
  end
endmodule

// File: tb/tb_dac_share_ctrl.sv
// tb_dac_share_ctrl: directed self-checking bench for dac_share_ctrl
module tb_dac_share_ctrl;
  logic clk = 0, n_reset = 0, enable = 0, davdac = 0;
  logic req_a = 0, req_b = 0;
  logic [11:0] data_a = 0, data_b = 0, dacdata;
  logic [1:0] cmd_a = 0, cmd_b = 0, daccmd;
  logic ack_a, ack_b, dacdav, busy, last_grant, timeout_err;
  int errors = 0, checks = 0;
  dac_share_ctrl #(.DW(12), .HOLDOFF(2), .TIMEOUT(64)) dut (
    .clk(clk), .n_reset(n_reset), .enable(enable),
    .req_a(req_a), .data_a(data_a), .cmd_a(cmd_a), .ack_a(ack_a),
    .req_b(req_b), .data_b(data_b), .cmd_b(cmd_b), .ack_b(ack_b),
    .dacdav(dacdav), .daccmd(daccmd), .dacdata(dacdata), .davdac(davdac),
    .busy(busy), .last_grant(last_grant), .timeout_err(timeout_err)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic wait_dav(input int max);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!dacdav && n < max);
    chk("dav_wait", dacdav, 1);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic bad;
    tick();
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_dav", dacdav, 0);
    chk("rst_ack", {ack_a, ack_b}, 0);
    chk("rst_data", dacdata, 0);
    chk("rst_cmd", daccmd, 0);
    chk("rst_lg", last_grant, 1);
    chk("rst_err", timeout_err, 0);
    // single port A
    n_reset = 1; enable = 1; req_a = 1; data_a = 12'h400; cmd_a = 2'b11;
    tick();
    chk("t1_ack_a", ack_a, 1);
    chk("t1_dav", dacdav, 1);
    chk("t1_ack_b", ack_b, 0);
    chk("t1_data", dacdata, 12'h400);
    chk("t1_cmd", daccmd, 2'b11);
    chk("t1_busy", busy, 1);
    chk("t1_lg", last_grant, 0);
    davdac = 1;
    tick();
    davdac = 0;
    chk("t1_pulse", {ack_a, dacdav}, 0);
    bad = 0;
    repeat (4) begin
      tick();
      if (dacdav || !busy) bad = 1;
    end
    chk("t1_stale", bad, 0);
    davdac = 1;
    tick();
    davdac = 0;
    chk("t1_hold1", {busy, dacdav}, 2'b10);
    tick();
    chk("t1_hold2", {busy, dacdav}, 2'b10);
    tick();
    chk("t1_idle", {busy, dacdav, ack_a}, 0);
    tick();
    chk("t1_next", {dacdav, ack_a}, 2'b11);
    req_a = 0;
    tick();
    davdac = 1;
    tick();
    davdac = 0;
    tick();
    tick();
    chk("t1_end", busy, 0);
    // contention from reset
    n_reset = 0;
    tick();
    n_reset = 1;
    req_a = 1; req_b = 1; data_a = 12'h111; data_b = 12'h222; cmd_a = 2'd1; cmd_b = 2'd2;
    for (int i = 0; i < 4; i++) begin
      wait_dav(20);
      chk("t2_ack_a", ack_a, (i % 2) == 0);
      chk("t2_ack_b", ack_b, (i % 2) == 1);
      chk("t2_data", dacdata, (i % 2) ? 12'h222 : 12'h111);
      chk("t2_cmd", daccmd, (i % 2) ? 2'd2 : 2'd1);
      repeat (2) tick();
      davdac = 1;
      tick();
      davdac = 0;
    end
    req_a = 0; req_b = 0;
    repeat (2) tick();
    chk("t2_idle", busy, 0);
    // timeout on port B
    req_b = 1; data_b = 12'h0ab; cmd_b = 2'd0;
    tick();
    chk("t3_grant", {ack_b, dacdav}, 2'b11);
    req_b = 0;
    bad = 0;
    for (int i = 1; i <= 62; i++) begin
      tick();
      if (dacdav || timeout_err || !busy) bad = 1;
    end
    chk("t3_wait", bad, 0);
    tick();
    chk("t3_err", timeout_err, 1);
    chk("t3_hold", busy, 1);
    tick();
    chk("t3_hold2", busy, 1);
    tick();
    chk("t3_idle", busy, 0);
    req_a = 1; data_a = 12'h333; cmd_a = 2'd2;
    tick();
    chk("t3_good", {ack_a, dacdav}, 2'b11);
    chk("t3_data", dacdata, 12'h333);
    req_a = 0;
    tick();
    davdac = 1;
    tick();
    davdac = 0;
    tick();
    tick();
    chk("t3_sticky", {busy, timeout_err}, 2'b01);
    // completion and timeout on the same edge
    n_reset = 0;
    tick();
    chk("t4_rst_err", timeout_err, 0);
    n_reset = 1; req_a = 1;
    tick();
    chk("t4_grant", dacdav, 1);
    req_a = 0;
    repeat (62) tick();
    davdac = 1;
    tick();
    davdac = 0;
    chk("t4_err", timeout_err, 0);
    chk("t4_hold", busy, 1);
    tick();
    chk("t4_hold2", busy, 1);
    tick();
    chk("t4_idle", {busy, timeout_err}, 0);
    // enable gating
    req_a = 1; data_a = 12'h0f0;
    tick();
    chk("t5_grant", {ack_a, dacdav}, 2'b11);
    enable = 0;
    tick();
    tick();
    davdac = 1;
    tick();
    davdac = 0;
    chk("t5_done", busy, 1);
    bad = 0;
    repeat (4) begin
      tick();
      if (ack_a || dacdav) bad = 1;
    end
    chk("t5_gated", bad, 0);
    chk("t5_idle", busy, 0);
    enable = 1;
    tick();
    chk("t5_regrant", {ack_a, dacdav}, 2'b11);
    req_a = 0;
    // reset mid-WAIT
    tick();
    n_reset = 0;
    tick();
    chk("t6_busy", busy, 0);
    chk("t6_data", dacdata, 0);
    chk("t6_lg", last_grant, 1);
    chk("t6_nostrobe", {ack_a, ack_b, dacdav}, 0);
    n_reset = 1; req_a = 1; req_b = 1; data_a = 12'h5a5; data_b = 12'ha5a;
    tick();
    chk("t6_ack", {ack_a, ack_b}, 2'b10);
    chk("t6_dat", dacdata, 12'h5a5);
    req_a = 0; req_b = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
